// File: rtl/ob_pkg.sv
// Shared types for the order-book table datapath: compressor selection and
// the table-count sequencer state encoding.
package ob_pkg;

   // Compression style used by the carry-save reduction tree.
   typedef enum logic [1:0] {
      CSA_3_2 = 2'd0,
      CSA_7_2 = 2'd1,
      CSA_ADD = 2'd2
   } csa_op_t;

   // Table-count sequencer states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      DRAIN   = 3'd2,
      RESOLVE = 3'd3,
      RESP    = 3'd4
   } ob_table_cnt_seq_state_t;

   // Words left after one 3:2 reduction level over 'live' words.
   function automatic int csa32_level_out(input int live);
      return 2 * (live / 3) + (live % 3);
   endfunction

   // Words left after one 7:3 reduction level over 'live' words.
   function automatic int csa73_level_out(input int live);
      return 3 * (live / 7) + (live % 7);
   endfunction

endpackage

// File: rtl/ob_table_cnt_csa.sv
// Combinational carry-save reduction of N words down to a sum/carry pair.
// All carries out of the top bit are dropped, so sum+carry equals the total
// of the inputs modulo 2^W. CSA_ADD collapses everything with a plain adder
// chain and returns a zero carry word.
module ob_table_cnt_csa
   import ob_pkg::*;
#(
   parameter int      W  = 32,
   parameter int      N  = 10,
   parameter csa_op_t OP = CSA_3_2
) (
   input  logic [N*W-1:0] in_words,
   output logic [W-1:0]   sum,
   output logic [W-1:0]   carry
);

   logic [W-1:0] work     [N];
   logic [W-1:0] nxt_work [N];
   logic [W-1:0] v0;
   logic [W-1:0] v1;
   logic [W-1:0] v2;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] c;
   logic [2:0]   bit_cnt;
   int           live;
   int           produced;

   // Reduce the live word set level by level until only two words remain.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         work[i]     = in_words[i*W +: W];
         nxt_work[i] = '0;
      end
      v0       = '0;
      v1       = '0;
      v2       = '0;
      a        = '0;
      b        = '0;
      c        = '0;
      bit_cnt  = '0;
      live     = N;
      produced = 0;
      sum      = '0;
      carry    = '0;

      if (OP == CSA_ADD) begin
         for (int i = 0; i < N; i++) begin
            sum = sum + work[i];
         end
      end else begin
         for (int lvl = 0; lvl < N; lvl++) begin
            if (live > 2) begin
               produced = 0;
               for (int i = 0; i < N; i++) begin
                  nxt_work[i] = '0;
               end
               if ((OP == CSA_7_2) && (live >= 7)) begin
                  // 7:3 column counters: each group of seven becomes three words
                  for (int g = 0; g < N / 7; g++) begin
                     if ((7 * g + 6) < live) begin
                        for (int bi = 0; bi < W; bi++) begin
                           bit_cnt = '0;
                           for (int j = 0; j < 7; j++) begin
                              bit_cnt = bit_cnt + {2'b00, work[7*g+j][bi]};
                           end
                           v0[bi] = bit_cnt[0];
                           v1[bi] = bit_cnt[1];
                           v2[bi] = bit_cnt[2];
                        end
                        nxt_work[produced]   = v0;
                        nxt_work[produced+1] = v1 << 1;
                        nxt_work[produced+2] = v2 << 2;
                        produced = produced + 3;
                     end
                  end
                  for (int i = 0; i < N; i++) begin
                     if ((i >= 7 * (live / 7)) && (i < live)) begin
                        nxt_work[produced] = work[i];
                        produced = produced + 1;
                     end
                  end
               end else begin
                  // 3:2 full-adder rows: each group of three becomes two words
                  for (int g = 0; g < N / 3; g++) begin
                     if ((3 * g + 2) < live) begin
                        a = work[3*g];
                        b = work[3*g+1];
                        c = work[3*g+2];
                        nxt_work[produced]   = a ^ b ^ c;
                        nxt_work[produced+1] = ((a & b) | (a & c) | (b & c)) << 1;
                        produced = produced + 2;
                     end
                  end
                  for (int i = 0; i < N; i++) begin
                     if ((i >= 3 * (live / 3)) && (i < live)) begin
                        nxt_work[produced] = work[i];
                        produced = produced + 1;
                     end
                  end
               end
               for (int i = 0; i < N; i++) begin
                  work[i] = nxt_work[i];
               end
               live = produced;
            end
         end
         sum   = work[0];
         carry = work[1];
      end
   end

endmodule

// File: rtl/ob_table_cnt_seq.sv
// Table-count sequencer: reads a wrapping range of table rows one per cycle,
// folds every returned row into a carry-save accumulator, resolves the total
// with a single carry-propagate add and hands it out on a valid/ready port.
module ob_table_cnt_seq
   import ob_pkg::*;
#(
   parameter int      W     = 32,
   parameter int      N     = 8,
   parameter int      DEPTH = 64,
   parameter csa_op_t OP    = CSA_3_2,
   localparam int     AW    = $clog2(DEPTH),
   localparam int     CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          cmd_vld,
   output logic          cmd_rdy,
   input  logic [AW-1:0] cmd_base,
   input  logic [CW-1:0] cmd_cnt,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [N*W-1:0] rd_data,
   output logic          rsp_vld,
   input  logic          rsp_rdy,
   output logic [W-1:0]  rsp_sum,
   output logic          busy
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   ob_table_cnt_seq_state_t state;
   ob_table_cnt_seq_state_t state_nxt;

   logic [CW-1:0] remain;
   logic          acc_en;
   logic [W-1:0]  s_acc;
   logic [W-1:0]  c_acc;
   logic [W-1:0]  csa_sum;
   logic [W-1:0]  csa_carry;
   logic          accept;

   assign accept = cmd_vld & cmd_rdy;

   // Row words plus the two accumulator words feed one reduction tree.
   ob_table_cnt_csa #(
      .W  (W),
      .N  (N + 2),
      .OP (OP)
   ) u_csa (
      .in_words ({c_acc, s_acc, rd_data}),
      .sum      (csa_sum),
      .carry    (csa_carry)
   );

   // State register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and the per-state handshake/read strobes.
   always_comb begin
      state_nxt = state;
      cmd_rdy   = 1'b0;
      rd_en     = 1'b0;
      rsp_vld   = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            cmd_rdy = 1'b1;
            busy    = 1'b0;
            if (cmd_vld) begin
               state_nxt = (cmd_cnt == '0) ? RESP : READ;
            end
         end
         READ: begin
            rd_en = 1'b1;
            if (remain == CW'(1)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = RESOLVE;
         end
         RESOLVE: begin
            state_nxt = RESP;
         end
         RESP: begin
            rsp_vld = 1'b1;
            if (rsp_rdy) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Read address walks forward from the base, wrapping at the last row.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rd_addr <= '0;
         remain  <= '0;
      end else if (accept) begin
         rd_addr <= cmd_base;
         remain  <= cmd_cnt;
      end else if (rd_en) begin
         rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + AW'(1);
         remain  <= remain - CW'(1);
      end
   end

   // Row data returns one cycle after its strobe; remember which cycles carry it.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         acc_en <= 1'b0;
      end else begin
         acc_en <= rd_en;
      end
   end

   // Carry-save accumulator, cleared when a new command is taken.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         s_acc <= '0;
         c_acc <= '0;
      end else if (accept) begin
         s_acc <= '0;
         c_acc <= '0;
      end else if (acc_en) begin
         s_acc <= csa_sum;
         c_acc <= csa_carry;
      end
   end

   // Result register: zero for empty ranges, otherwise the resolved total.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rsp_sum <= '0;
      end else if (accept && (cmd_cnt == '0)) begin
         rsp_sum <= '0;
      end else if (state == RESOLVE) begin
         rsp_sum <= s_acc + c_acc;
      end
   end

endmodule
